mm_tile_sched: RTL and testbench
================================

MM_TILE_SCHED -- requirements
Module: mm_tile_sched

Interface
REQ-001 SHALL have parameter MATRIXSIZE_W, default 16, width of matrix-dimension fields.
REQ-002 SHALL have parameter ADDR_W_A, default 12, width of the A-buffer base address.
REQ-003 SHALL have parameter ADDR_W_B, default 12, width of the B-buffer base address.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cfg_valid  input  1  job descriptor valid.
REQ-007 SHALL have port cfg_ready  output  1  scheduler can accept a descriptor.
REQ-008 SHALL have ports cfg_M2, cfg_M1dN1, cfg_M3dN2  input  MATRIXSIZE_W each  inner dimension, A row-tile count, B column-tile count.
REQ-009 SHALL have ports a_loaded, b_loaded  input  1 each  level signals: A/B buffers fully written.
REQ-010 SHALL have port abort  input  1  synchronous job cancel.
REQ-011 SHALL have port tile_start  output  1  one-cycle pulse that launches one systolic tile.
REQ-012 SHALL have ports base_addr_A, base_addr_B  output  ADDR_W_A / ADDR_W_B  read base addresses for the current tile.
REQ-013 SHALL have ports tile_row, tile_col  output  MATRIXSIZE_W each  current tile indices.
REQ-014 SHALL have port tile_done  input  1  pulse from the array: tile result ready.
REQ-015 SHALL have ports drain_valid (output, 1) and drain_ready (input, 1)  result-drain handshake.
REQ-016 SHALL have ports busy, job_done, err_cfg  output  1 each  job active, end-of-job pulse, bad-descriptor pulse.
REQ-017 SHALL have port perf_cycles  output  32  cycle count of the last or current job.

Function
REQ-018 FSM SHALL have the states IDLE, WAIT_LOAD, ISSUE, COMPUTE, DRAIN, DONE; all outputs SHALL be registered or decoded from state only (Moore).
REQ-019 IDLE: cfg_ready=1; on cfg_valid the descriptor SHALL be latched; any field zero -> err_cfg=1 the next cycle, remain in IDLE; otherwise -> WAIT_LOAD, with row=col=0 and both bases=0.
REQ-020 WAIT_LOAD: a_loaded && b_loaded -> ISSUE; otherwise hold.
REQ-021 ISSUE: tile_start=1 for exactly this one cycle -> COMPUTE.
REQ-022 COMPUTE: tile_done -> DRAIN; tile_done in any other state SHALL be ignored.
REQ-023 DRAIN: drain_valid=1 with tile_row/tile_col stable until drain_valid && drain_ready.
REQ-024 On the drain handshake the tile SHALL advance col-inner, row-outer:
- col<M3dN2-1: col+1, base_addr_B += M2.
- else: col=0, base_addr_B=0, row+1, base_addr_A += M2.
REQ-025 On a drain handshake for the last tile (row=M1dN1-1, col=M3dN2-1) the FSM SHALL go -> DONE; otherwise -> ISSUE.
REQ-026 Base addresses SHALL equal row*M2 and col*M2 modulo 2^ADDR_W, produced by accumulation, with no multiplier.
REQ-027 DONE: job_done=1 for one cycle -> IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 perf_cycles SHALL clear on descriptor accept, increment once per cycle while busy, saturate at 2^32-1, and hold after DONE.
REQ-030 abort SHALL send any non-IDLE state -> IDLE next cycle: tile_start/drain_valid deasserted, no job_done, perf_cycles held. abort has priority over every other transition in the same cycle.
REQ-031 Latency from descriptor accept in cycle t, with loads already high, SHALL be: tile_start in cycle t+2.
REQ-032 Latency from drain handshake to next tile_start SHALL be 1 cycle.

Reset
REQ-033 On rst=1 the block SHALL enter IDLE, with cfg_ready=1 and every other output 0 (including perf_cycles, counters and bases).
REQ-034 rst SHALL override abort and all other inputs, including mid-job.

Verification
REQ-035 M2=8, M1dN1=2, M3dN2=3, loads high -> 6 tile_start pulses in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); base_addr_B 0/8/16; base_addr_A 0 then 8; then one job_done.
REQ-036 cfg_M3dN2=0 -> err_cfg pulse one cycle later, busy stays 0, no tile_start.
REQ-037 drain_ready held low 5 cycles in DRAIN -> drain_valid, tile_row, tile_col stable all 5 cycles; advance only on the handshake cycle.
REQ-038 abort asserted in COMPUTE together with tile_done -> IDLE next cycle, no DRAIN, no job_done.
REQ-039 tile_done pulsed in WAIT_LOAD, and b_loaded asserted 10 cycles after a_loaded -> pulse ignored; tile_start 1 cycle after both loads are high.
REQ-040 rst asserted mid-DRAIN -> all outputs at reset values next cycle; a following 1x1x1 job (M2=4) completes with perf_cycles = 5 when drain_ready is held high.

Source files
------------

// File: rtl/mm_tile_sched_if.sv
// Signal bundle between the tile scheduler, its job host, the A/B buffers and the systolic array.
// master = host/array side, slave = scheduler side.
interface mm_tile_sched_if #(
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W_A     = 12,
    parameter int ADDR_W_B     = 12
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [MATRIXSIZE_W-1:0] cfg_M2;
    logic [MATRIXSIZE_W-1:0] cfg_M1dN1;
    logic [MATRIXSIZE_W-1:0] cfg_M3dN2;
    logic                    a_loaded;
    logic                    b_loaded;
    logic                    abort;
    logic                    tile_start;
    logic [ADDR_W_A-1:0]     base_addr_A;
    logic [ADDR_W_B-1:0]     base_addr_B;
    logic [MATRIXSIZE_W-1:0] tile_row;
    logic [MATRIXSIZE_W-1:0] tile_col;
    logic                    tile_done;
    logic                    drain_valid;
    logic                    drain_ready;
    logic                    busy;
    logic                    job_done;
    logic                    err_cfg;
    logic [31:0]             perf_cycles;

    modport master (
        output cfg_valid, cfg_M2, cfg_M1dN1, cfg_M3dN2, a_loaded, b_loaded, abort,
               tile_done, drain_ready,
        input  cfg_ready, tile_start, base_addr_A, base_addr_B, tile_row, tile_col,
               drain_valid, busy, job_done, err_cfg, perf_cycles
    );

    modport slave (
        input  cfg_valid, cfg_M2, cfg_M1dN1, cfg_M3dN2, a_loaded, b_loaded, abort,
               tile_done, drain_ready,
        output cfg_ready, tile_start, base_addr_A, base_addr_B, tile_row, tile_col,
               drain_valid, busy, job_done, err_cfg, perf_cycles
    );
endinterface

// File: rtl/mm_tile_sched.sv
// Walks a matrix job tile by tile (col-inner, row-outer); tile_start 2 cycles after accept, 1 after each drain.
// Backpressure: stays in DRAIN with tile indices frozen until drain_ready; cfg_ready only while IDLE.
module mm_tile_sched #(
    parameter int MATRIXSIZE_W = 16,
    parameter int ADDR_W_A     = 12,
    parameter int ADDR_W_B     = 12
) (
    input  logic           clk,
    input  logic           rst,
    mm_tile_sched_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOAD,
        ISSUE,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [MATRIXSIZE_W-1:0] DIM_ONE = 1;

    state_t                  state_q, state_d;
    logic [MATRIXSIZE_W-1:0] m2_q, m2_d;
    logic [MATRIXSIZE_W-1:0] m1_q, m1_d;
    logic [MATRIXSIZE_W-1:0] m3_q, m3_d;
    logic [MATRIXSIZE_W-1:0] row_q, row_d;
    logic [MATRIXSIZE_W-1:0] col_q, col_d;
    logic [ADDR_W_A-1:0]     base_a_q, base_a_d;
    logic [ADDR_W_B-1:0]     base_b_q, base_b_d;
    logic [31:0]             perf_q, perf_d;
    logic                    err_q, err_d;

    logic accept;
    logic cfg_bad;
    logic abort_act;
    logic drain_adv;
    logic last_row;
    logic last_col;

    always_comb begin
        accept    = (state_q == IDLE) && bus.cfg_valid;
        cfg_bad   = (bus.cfg_M2 == '0) || (bus.cfg_M1dN1 == '0) || (bus.cfg_M3dN2 == '0);
        abort_act = bus.abort && (state_q != IDLE);
        drain_adv = (state_q == DRAIN) && bus.drain_ready && !bus.abort;
        last_row  = (row_q == m1_q - DIM_ONE);
        last_col  = (col_q == m3_q - DIM_ONE);
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept && !cfg_bad) state_d = WAIT_LOAD;
            WAIT_LOAD: if (bus.a_loaded && bus.b_loaded) state_d = ISSUE;
            ISSUE:     state_d = COMPUTE;
            COMPUTE:   if (bus.tile_done) state_d = DRAIN;
            DRAIN:     if (bus.drain_ready) state_d = (last_row && last_col) ? DONE : ISSUE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (abort_act) begin
            state_d = IDLE;
        end
    end

    // Descriptor, tile walk and cycle counter.
    always_comb begin
        m2_d     = m2_q;
        m1_d     = m1_q;
        m3_d     = m3_q;
        row_d    = row_q;
        col_d    = col_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        perf_d   = perf_q;
        err_d    = 1'b0;

        if (accept) begin
            m2_d  = bus.cfg_M2;
            m1_d  = bus.cfg_M1dN1;
            m3_d  = bus.cfg_M3dN2;
            err_d = cfg_bad;
            if (!cfg_bad) begin
                row_d    = '0;
                col_d    = '0;
                base_a_d = '0;
                base_b_d = '0;
                perf_d   = '0;
            end
        end

        // Bases track row*M2 / col*M2 by accumulation, wrapping at the address width.
        if (drain_adv) begin
            if (!last_col) begin
                col_d    = col_q + DIM_ONE;
                base_b_d = base_b_q + ADDR_W_B'(m2_q);
            end else begin
                col_d    = '0;
                base_b_d = '0;
                row_d    = row_q + DIM_ONE;
                base_a_d = base_a_q + ADDR_W_A'(m2_q);
            end
        end

        // The abort cycle itself is not counted: the count freezes at the last full job cycle.
        if ((state_q != IDLE) && !bus.abort && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            m2_q     <= '0;
            m1_q     <= '0;
            m3_q     <= '0;
            row_q    <= '0;
            col_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            perf_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            m2_q     <= m2_d;
            m1_q     <= m1_d;
            m3_q     <= m3_d;
            row_q    <= row_d;
            col_q    <= col_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            perf_q   <= perf_d;
            err_q    <= err_d;
        end
    end

    assign bus.cfg_ready   = (state_q == IDLE);
    assign bus.tile_start  = (state_q == ISSUE);
    assign bus.drain_valid = (state_q == DRAIN);
    assign bus.job_done    = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.err_cfg     = err_q;
    assign bus.tile_row    = row_q;
    assign bus.tile_col    = col_q;
    assign bus.base_addr_A = base_a_q;
    assign bus.base_addr_B = base_b_q;
    assign bus.perf_cycles = perf_q;
endmodule

// File: tb/tb_mm_tile_sched.sv
// Scoreboard bench for mm_tile_sched: expected tiles are queued at job start and popped on tile_start.
module tb_mm_tile_sched;
    localparam int MW  = 16;
    localparam int AWA = 12;
    localparam int AWB = 12;

    logic clk = 1'b0;
    logic rst;

    mm_tile_sched_if #(.MATRIXSIZE_W(MW), .ADDR_W_A(AWA), .ADDR_W_B(AWB)) bus ();

    mm_tile_sched #(.MATRIXSIZE_W(MW), .ADDR_W_A(AWA), .ADDR_W_B(AWB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        int ba;
        int bb;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total   = 0;
    int   bad     = 0;
    int   n_start = 0;
    int   n_done  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every tile_start is matched against the oldest expected tile.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.tile_start === 1'b1) begin
            n_start++;
            if (sb.size() == 0) begin
                chk("extra_tile", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("tile_row", bus.tile_row, mon_e.r);
                chk("tile_col", bus.tile_col, mon_e.c);
                chk("base_a", bus.base_addr_A, mon_e.ba);
                chk("base_b", bus.base_addr_B, mon_e.bb);
            end
        end
        if (rst === 1'b0 && bus.job_done === 1'b1) n_done++;
    end

    task automatic check_idle(input string tag);
        chk({tag, "_cfg_ready"}, bus.cfg_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_tile_start"}, bus.tile_start, 0);
        chk({tag, "_drain_valid"}, bus.drain_valid, 0);
        chk({tag, "_job_done"}, bus.job_done, 0);
        chk({tag, "_err_cfg"}, bus.err_cfg, 0);
        chk({tag, "_perf"}, bus.perf_cycles, 0);
        chk({tag, "_row"}, bus.tile_row, 0);
        chk({tag, "_col"}, bus.tile_col, 0);
        chk({tag, "_base_a"}, bus.base_addr_A, 0);
        chk({tag, "_base_b"}, bus.base_addr_B, 0);
    endtask

    // Queue expected tiles, then present the descriptor for one cycle.
    task automatic start_job(input int m2, input int m1, input int m3);
        exp_t e;
        for (int r = 0; r < m1; r++) begin
            for (int c = 0; c < m3; c++) begin
                e.r  = r;
                e.c  = c;
                e.ba = (r * m2) & ((1 << AWA) - 1);
                e.bb = (c * m2) & ((1 << AWB) - 1);
                sb.push_back(e);
            end
        end
        bus.cfg_M2    = MW'(m2);
        bus.cfg_M1dN1 = MW'(m1);
        bus.cfg_M3dN2 = MW'(m3);
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
    endtask

    // Act as the array and drain sink for every tile, then check the job end.
    task automatic serve_tiles(input int m1, input int m3, input int stall_idx, input int stall_n);
        int n;
        int idx;
        idx = 0;
        for (int r = 0; r < m1; r++) begin
            for (int c = 0; c < m3; c++) begin
                n = 0;
                while (bus.tile_start !== 1'b1 && n < 20) begin
                    step();
                    n++;
                end
                chk("start_lat", n, (idx == 0) ? 1 : 0);
                step();
                chk("early_drain", bus.drain_valid, 0);
                bus.tile_done = 1'b1;
                step();
                bus.tile_done = 1'b0;
                chk("drain_vld", bus.drain_valid, 1);
                if (idx == stall_idx) begin
                    for (int s = 0; s < stall_n; s++) begin
                        step();
                        chk("stall_vld", bus.drain_valid, 1);
                        chk("stall_row", bus.tile_row, r);
                        chk("stall_col", bus.tile_col, c);
                    end
                end
                bus.drain_ready = 1'b1;
                step();
                bus.drain_ready = 1'b0;
                idx++;
            end
        end
        chk("job_done", bus.job_done, 1);
        step();
        chk("done_clr", bus.job_done, 0);
        chk("end_busy", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int d0;
        rst             = 1'b1;
        bus.cfg_valid   = 1'b0;
        bus.cfg_M2      = '0;
        bus.cfg_M1dN1   = '0;
        bus.cfg_M3dN2   = '0;
        bus.a_loaded    = 1'b0;
        bus.b_loaded    = 1'b0;
        bus.abort       = 1'b0;
        bus.tile_done   = 1'b0;
        bus.drain_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check_idle("rst");

        // 2x3 tile grid, drain stalled 5 cycles on tile (1,1).
        bus.a_loaded = 1'b1;
        bus.b_loaded = 1'b1;
        s0 = n_start;
        d0 = n_done;
        start_job(8, 2, 3);
        serve_tiles(2, 3, 4, 5);
        chk("job1_starts", n_start - s0, 6);
        chk("job1_dones", n_done - d0, 1);
        chk("job1_perf", bus.perf_cycles, 25);
        repeat (2) step();
        chk("job1_perf_hold", bus.perf_cycles, 25);

        // Base address wrap at 12 bits (3*1500 = 4500 -> 404).
        start_job(1500, 4, 2);
        serve_tiles(4, 2, -1, 0);

        // Zero dimension is rejected.
        s0 = n_start;
        bus.cfg_M2    = 16'd4;
        bus.cfg_M1dN1 = 16'd2;
        bus.cfg_M3dN2 = 16'd0;
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        chk("err_pulse", bus.err_cfg, 1);
        chk("err_busy", bus.busy, 0);
        step();
        chk("err_clr", bus.err_cfg, 0);
        chk("err_busy2", bus.busy, 0);
        chk("err_no_start", n_start - s0, 0);

        // Abort together with tile_done in COMPUTE.
        d0 = n_done;
        start_job(4, 1, 1);
        step();
        chk("abort_issue", bus.tile_start, 1);
        step();
        bus.tile_done = 1'b1;
        bus.abort     = 1'b1;
        step();
        bus.tile_done = 1'b0;
        bus.abort     = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_drain", bus.drain_valid, 0);
        chk("abort_ready", bus.cfg_ready, 1);
        chk("abort_perf", bus.perf_cycles, 2);
        repeat (3) step();
        chk("abort_perf_hold", bus.perf_cycles, 2);
        chk("abort_no_done", n_done - d0, 0);

        // Late b_loaded and a stray tile_done while waiting for loads.
        bus.a_loaded = 1'b0;
        bus.b_loaded = 1'b0;
        s0 = n_start;
        start_job(5, 1, 1);
        bus.tile_done = 1'b1;
        bus.a_loaded  = 1'b1;
        step();
        bus.tile_done = 1'b0;
        repeat (9) step();
        chk("wait_no_start", n_start - s0, 0);
        chk("wait_busy", bus.busy, 1);
        bus.b_loaded = 1'b1;
        serve_tiles(1, 1, -1, 0);

        // Reset in the middle of a drain, then a minimal job.
        start_job(3, 2, 2);
        step();
        chk("rstjob_issue", bus.tile_start, 1);
        step();
        bus.tile_done = 1'b1;
        step();
        bus.tile_done = 1'b0;
        chk("rstjob_drain", bus.drain_valid, 1);
        rst = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_idle("mid_rst");
        rst = 1'b0;
        sb.delete();
        step();
        start_job(4, 1, 1);
        serve_tiles(1, 1, -1, 0);
        chk("min_perf", bus.perf_cycles, 5);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
